// File: rtl/vehicle_powertrain_core.sv
`default_nettype none
// ============================================================================
//  Module      : vehicle_powertrain_core
//  Description : Speed/RPM physics with an N-speed automatic transmission.
//                Timed up/down shifts with hysteresis and torque cut,
//                brake deceleration bands, emergency-stop request and a
//                registered RPM with a small jitter dither.
//  Revision    : 1.0  initial release
// ============================================================================
module vehicle_powertrain_core #(
  parameter int NUM_GEARS   = 6,
  parameter int GEAR_BAND   = 30,
  parameter int HYST        = 5,
  parameter int SHIFT_TICKS = 3,
  parameter int IDLE_RPM    = 800,
  parameter int RPM_PER_KMH = 35,
  parameter int PN_LIMIT    = 4000,
  parameter int REDLINE     = 8000,
  parameter int MAX_SPEED   = 250,
  parameter int REV_SPEED   = 50,
  parameter int DEADZONE    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        engine_on,
  input  logic        tick_speed,
  input  logic [1:0]  mode,
  input  logic [7:0]  accel,
  input  logic        brake_normal,
  input  logic        brake_hard,
  output logic [7:0]  speed,
  output logic [13:0] rpm,
  output logic [3:0]  gear_num,
  output logic        shifting,
  output logic        ess_trigger
);

  localparam logic [1:0]  C_MODE_P = 2'd0;
  localparam logic [1:0]  C_MODE_R = 2'd1;
  localparam logic [1:0]  C_MODE_N = 2'd2;
  localparam logic [1:0]  C_MODE_D = 2'd3;
  localparam int          CNT_W    = (SHIFT_TICKS > 1) ? $clog2(SHIFT_TICKS) : 1;
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(SHIFT_TICKS - 1);
  localparam logic [19:0] C_BAND   = 20'(GEAR_BAND);
  localparam logic [19:0] C_HYST   = 20'(HYST);
  localparam logic [19:0] C_IDLE   = 20'(IDLE_RPM);
  localparam logic [19:0] C_SLOPE  = 20'(RPM_PER_KMH);
  localparam logic [19:0] C_PNLIM  = 20'(PN_LIMIT);
  localparam logic [19:0] C_RED    = 20'(REDLINE);
  localparam logic [3:0]  C_GEARS  = 4'(NUM_GEARS);

  typedef enum logic [1:0] {ST_HOLD = 2'd0, ST_UP = 2'd1, ST_DN = 2'd2} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gear_q, gear_d;
  logic             shifting_q, shifting_d;
  logic [7:0]       speed_q, speed_d;
  logic             ess_q, ess_d;
  logic [13:0]      rpm_q, rpm_d;
  logic [1:0]       jitter_q, jitter_d;

  logic        tick_en;
  logic [7:0]  eff;
  logic [19:0] spd20, eff20, power20, res20, up_thr, dn_thr;
  logic [7:0]  hard_dec, norm_dec;
  logic [19:0] base_kmh, rd_sum, pn_sum;
  logic [13:0] pn_clamped;

  assign tick_en = engine_on & tick_speed;
  assign eff     = (accel > 8'(DEADZONE)) ? (accel - 8'(DEADZONE)) : 8'd0;
  assign spd20   = {12'd0, speed_q};
  assign eff20   = {12'd0, eff};
  // Shift thresholds are always taken against the gear currently engaged.
  assign up_thr  = {16'd0, gear_q} * C_BAND;
  assign dn_thr  = ({16'd0, gear_q} - 20'd1) * C_BAND;

  // Gear FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= ST_HOLD;
      cnt_q      <= '0;
      gear_q     <= 4'd1;
      shifting_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      gear_q     <= gear_d;
      shifting_q <= shifting_d;
    end
  end

  // Gear FSM next state: shift decisions, shift timer, abort outside D.
  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    gear_d = gear_q;
    if (!engine_on) begin
      fsm_d  = ST_HOLD;
      cnt_d  = '0;
      gear_d = 4'd1;
    end else if (tick_speed) begin
      if (mode != C_MODE_D) begin
        fsm_d  = ST_HOLD;
        cnt_d  = '0;
        gear_d = 4'd1;
      end else begin
        case (fsm_q)
          ST_HOLD: begin
            if ((gear_q < C_GEARS) && (spd20 >= up_thr)) begin
              fsm_d = ST_UP;
              cnt_d = C_CNT_INIT;
            end else if ((gear_q > 4'd1) && ((spd20 + C_HYST) < dn_thr)) begin
              fsm_d = ST_DN;
              cnt_d = C_CNT_INIT;
            end
          end
          ST_UP, ST_DN: begin
            if (cnt_q == '0) begin
              gear_d = (fsm_q == ST_UP) ? gear_q + 4'd1 : gear_q - 4'd1;
              fsm_d  = ST_HOLD;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          default: fsm_d = ST_HOLD;
        endcase
      end
    end
    shifting_d = (fsm_d != ST_HOLD);
  end

  // Tractive power and road resistance; power is cut while a shift runs.
  always_comb begin
    power20 = 20'd0;
    if (!shifting_q) begin
      if (mode == C_MODE_D)      power20 = eff20;
      else if (mode == C_MODE_R) power20 = eff20 >> 1;
    end
    res20    = spd20 + 20'd5 + ((speed_q >= 8'd180) ? 20'd100 : 20'd0);
    hard_dec = (speed_q <= 8'd80) ? 8'd8 : (speed_q <= 8'd150) ? 8'd4 : 8'd2;
    norm_dec = (speed_q <= 8'd80) ? 8'd3 : (speed_q <= 8'd150) ? 8'd2 : 8'd1;
  end

  // Speed update and emergency-stop request, brakes taking priority.
  always_comb begin
    speed_d = speed_q;
    ess_d   = ess_q;
    if (!engine_on) begin
      speed_d = 8'd0;
      ess_d   = 1'b0;
    end else if (tick_speed) begin
      ess_d = 1'b0;
      if (brake_hard) begin
        speed_d = (speed_q > hard_dec) ? speed_q - hard_dec : 8'd0;
        ess_d   = (speed_q > 8'd50);
      end else if (brake_normal) begin
        speed_d = (speed_q > norm_dec) ? speed_q - norm_dec : 8'd0;
      end else if (power20 > res20) begin
        if (!((speed_q >= 8'(MAX_SPEED)) ||
              ((mode == C_MODE_R) && (speed_q >= 8'(REV_SPEED)))))
          speed_d = speed_q + 8'd1;
      end else if ((power20 < res20) && (speed_q != 8'd0)) begin
        speed_d = speed_q - 8'd1;
      end
    end
  end

  // RPM from pre-update speed, gear and jitter; limiter in P/N, redline in R/D.
  always_comb begin
    rpm_d      = rpm_q;
    jitter_d   = jitter_q;
    base_kmh   = (spd20 >= dn_thr) ? (spd20 - dn_thr) : 20'd0;
    rd_sum     = C_IDLE + base_kmh * C_SLOPE + (eff20 << 1) + {18'd0, jitter_q};
    pn_sum     = C_IDLE + {12'd0, accel} * 20'd20;
    pn_clamped = (pn_sum > C_PNLIM) ? 14'(PN_LIMIT) : pn_sum[13:0];
    if (!engine_on) begin
      rpm_d    = 14'd0;
      jitter_d = 2'd0;
    end else if (tick_speed) begin
      jitter_d = jitter_q + 2'd1;
      if ((mode == C_MODE_P) || (mode == C_MODE_N))
        rpm_d = pn_clamped + {12'd0, jitter_q};
      else
        rpm_d = (rd_sum > C_RED) ? 14'(REDLINE) : rd_sum[13:0];
    end
  end

  // Physics state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_q  <= 8'd0;
      ess_q    <= 1'b0;
      rpm_q    <= 14'd0;
      jitter_q <= 2'd0;
    end else begin
      speed_q  <= speed_d;
      ess_q    <= ess_d;
      rpm_q    <= rpm_d;
      jitter_q <= jitter_d;
    end
  end

  assign speed       = speed_q;
  assign rpm         = rpm_q;
  assign gear_num    = gear_q;
  assign shifting    = shifting_q;
  assign ess_trigger = ess_q;

  // C_MODE_N is named for readability of the mode decode above.
  logic unused_ok;
  assign unused_ok = &{1'b0, tick_en, C_MODE_N};

endmodule
`default_nettype wire

// File: tb/tb_vehicle_powertrain_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vehicle_powertrain_core
//  Description : Self-checking bench: directed vector table from reset plus
//                hand-written multi-cycle sequences (shifts, brakes, aborts).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vehicle_powertrain_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        engine_on = 1'b1;
  logic        tick_speed = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  accel = 8'd0;
  logic        brake_normal = 1'b0;
  logic        brake_hard = 1'b0;
  logic [7:0]  speed;
  logic [13:0] rpm;
  logic [3:0]  gear_num;
  logic        shifting;
  logic        ess_trigger;

  int checks = 0;
  int failures = 0;

  vehicle_powertrain_core dut (
    .clk(clk), .rst(rst), .engine_on(engine_on), .tick_speed(tick_speed),
    .mode(mode), .accel(accel), .brake_normal(brake_normal),
    .brake_hard(brake_hard), .speed(speed), .rpm(rpm), .gear_num(gear_num),
    .shifting(shifting), .ess_trigger(ess_trigger)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  accel;
    logic        bn;
    logic        bh;
    int          ticks;
    logic [7:0]  e_speed;
    logic [13:0] e_rpm;
    logic [3:0]  e_gear;
    logic        e_shift;
    logic        e_ess;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    tick_speed = 1'b1;
    @(posedge clk);
    #1;
    tick_speed = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    engine_on = 1'b1;
    brake_normal = 1'b0;
    brake_hard = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] a, input logic bn, input logic bh);
    mode = m;
    accel = a;
    brake_normal = bn;
    brake_hard = bh;
  endtask

  initial begin
    int n;
    int max_spd;
    int prev_gear;
    int skips;
    bit hit;

    // mode, accel, bn, bh, ticks, speed, rpm, gear, shift, ess
    vecs[0]  = '{2'd0, 8'd255, 1'b0, 1'b0, 1, 8'd0, 14'd4000, 4'd1, 1'b0, 1'b0};
    vecs[1]  = '{2'd0, 8'd255, 1'b0, 1'b0, 3, 8'd0, 14'd4002, 4'd1, 1'b0, 1'b0};
    vecs[2]  = '{2'd2, 8'd100, 1'b0, 1'b0, 2, 8'd0, 14'd2801, 4'd1, 1'b0, 1'b0};
    vecs[3]  = '{2'd2, 8'd10,  1'b0, 1'b0, 5, 8'd0, 14'd1000, 4'd1, 1'b0, 1'b0};
    vecs[4]  = '{2'd3, 8'd255, 1'b0, 1'b0, 1, 8'd1, 14'd1300, 4'd1, 1'b0, 1'b0};
    vecs[5]  = '{2'd3, 8'd255, 1'b0, 1'b0, 4, 8'd4, 14'd1408, 4'd1, 1'b0, 1'b0};
    vecs[6]  = '{2'd3, 8'd5,   1'b0, 1'b0, 2, 8'd0, 14'd801,  4'd1, 1'b0, 1'b0};
    vecs[7]  = '{2'd3, 8'd6,   1'b0, 1'b0, 3, 8'd0, 14'd804,  4'd1, 1'b0, 1'b0};
    vecs[8]  = '{2'd1, 8'd255, 1'b0, 1'b0, 2, 8'd2, 14'd1336, 4'd1, 1'b0, 1'b0};
    vecs[9]  = '{2'd3, 8'd255, 1'b0, 1'b1, 2, 8'd0, 14'd1301, 4'd1, 1'b0, 1'b0};
    vecs[10] = '{2'd3, 8'd255, 1'b1, 1'b0, 1, 8'd0, 14'd1300, 4'd1, 1'b0, 1'b0};
    vecs[11] = '{2'd1, 8'd20,  1'b0, 1'b0, 3, 8'd2, 14'd902,  4'd1, 1'b0, 1'b0};
    vecs[12] = '{2'd3, 8'd15,  1'b0, 1'b0, 8, 8'd5, 14'd998,  4'd1, 1'b0, 1'b0};
    vecs[13] = '{2'd0, 8'd160, 1'b0, 1'b0, 1, 8'd0, 14'd4000, 4'd1, 1'b0, 1'b0};
    vecs[14] = '{2'd0, 8'd159, 1'b0, 1'b0, 2, 8'd0, 14'd3981, 4'd1, 1'b0, 1'b0};

    // Reset state
    do_reset();
    check("rst_speed", speed, 0);
    check("rst_rpm", rpm, 0);
    check("rst_gear", gear_num, 1);
    check("rst_shift", shifting, 0);
    check("rst_ess", ess_trigger, 0);

    // Vector table, each from a fresh reset
    for (int v = 0; v < 15; v++) begin
      do_reset();
      drive(vecs[v].mode, vecs[v].accel, vecs[v].bn, vecs[v].bh);
      for (int t = 0; t < vecs[v].ticks; t++) tick();
      check($sformatf("vec%0d_speed", v), speed, vecs[v].e_speed);
      check($sformatf("vec%0d_rpm", v), rpm, vecs[v].e_rpm);
      check($sformatf("vec%0d_gear", v), gear_num, vecs[v].e_gear);
      check($sformatf("vec%0d_shift", v), shifting, vecs[v].e_shift);
      check($sformatf("vec%0d_ess", v), ess_trigger, vecs[v].e_ess);
    end

    // Upshift 1->2 at 30 km/h with three-tick torque cut
    do_reset();
    drive(2'd3, 8'd255, 1'b0, 1'b0);
    for (int t = 0; t < 30; t++) tick();
    check("up_pre_speed", speed, 30);
    check("up_pre_rpm", rpm, 2316);
    check("up_pre_shift", shifting, 0);
    tick();
    check("up_t1_shift", shifting, 1);
    check("up_t1_speed", speed, 31);
    check("up_t1_gear", gear_num, 1);
    tick();
    check("up_t2_shift", shifting, 1);
    check("up_t2_speed", speed, 30);
    tick();
    check("up_t3_shift", shifting, 1);
    check("up_t3_speed", speed, 29);
    check("up_t3_gear", gear_num, 1);
    tick();
    check("up_done_shift", shifting, 0);
    check("up_done_gear", gear_num, 2);
    check("up_done_speed", speed, 28);
    tick();
    check("up_after_speed", speed, 29);
    check("up_after_rpm", rpm, 1302);

    // Ramp to 100 km/h in gear 4, then service-brake down to a 4->3 shift
    prev_gear = gear_num;
    skips = 0;
    hit = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      tick();
      if ((gear_num > prev_gear + 1) || (gear_num + 1 < prev_gear)) skips++;
      prev_gear = gear_num;
      if (gear_num == 4 && speed == 100 && !shifting) hit = 1'b1;
    end
    check("ramp100_reached", hit, 1);
    drive(2'd3, 8'd0, 1'b1, 1'b0);
    n = 0;
    hit = 1'b0;
    for (int t = 0; t < 20 && !hit; t++) begin
      tick();
      n++;
      if ((gear_num > prev_gear + 1) || (gear_num + 1 < prev_gear)) skips++;
      prev_gear = gear_num;
      if (shifting) hit = 1'b1;
    end
    check("dn_start_tick", n, 9);
    check("dn_start_speed", speed, 82);
    check("dn_start_gear", gear_num, 4);
    tick();
    tick();
    check("dn_band_speed", speed, 77);
    tick();
    check("dn_done_gear", gear_num, 3);
    check("dn_done_shift", shifting, 0);
    check("dn_done_speed", speed, 74);
    check("gear_no_skip", skips, 0);

    // Hard brake from 60 km/h
    do_reset();
    drive(2'd3, 8'd255, 1'b0, 1'b0);
    hit = 1'b0;
    for (int t = 0; t < 120 && !hit; t++) begin
      tick();
      if (speed == 60 && gear_num == 2) hit = 1'b1;
    end
    check("hb_reach60", hit, 1);
    drive(2'd3, 8'd0, 1'b0, 1'b1);
    tick();
    check("hb1_speed", speed, 52);
    check("hb1_ess", ess_trigger, 1);
    tick();
    check("hb2_speed", speed, 44);
    check("hb2_ess", ess_trigger, 1);
    repeat (3) @(posedge clk);
    #1;
    check("hb_hold_ess", ess_trigger, 1);
    check("hb_hold_speed", speed, 44);
    tick();
    check("hb3_speed", speed, 36);
    check("hb3_ess", ess_trigger, 0);

    // Mid-upshift (gear 3, cnt=1) switched to N
    do_reset();
    drive(2'd3, 8'd255, 1'b0, 1'b0);
    hit = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      tick();
      if (speed == 90 && gear_num == 3 && !shifting) hit = 1'b1;
    end
    check("ab_reach90", hit, 1);
    tick();
    tick();
    check("ab_mid_shift", shifting, 1);
    check("ab_mid_speed", speed, 90);
    mode = 2'd2;
    tick();
    check("ab_gear", gear_num, 1);
    check("ab_shift", shifting, 0);
    check("ab_speed", speed, 89);
    tick();
    check("ab_nopower_speed", speed, 88);

    // P-mode rev limiter with jitter, then engine off
    do_reset();
    drive(2'd3, 8'd255, 1'b0, 1'b0);
    for (int t = 0; t < 10; t++) tick();
    mode = 2'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("pn_rpm%0d", k), rpm, 4000 + ((10 + k) % 4));
    end
    check("pn_speed", speed, 5);
    engine_on = 1'b0;
    @(posedge clk);
    #1;
    check("eoff_speed", speed, 0);
    check("eoff_rpm", rpm, 0);
    check("eoff_gear", gear_num, 1);
    engine_on = 1'b1;
    tick();
    check("eon_rpm_jit0", rpm, 4000);

    // Reverse saturation at 50, then asynchronous reset
    do_reset();
    drive(2'd1, 8'd255, 1'b0, 1'b0);
    max_spd = 0;
    for (int t = 0; t < 70; t++) begin
      tick();
      if (speed > max_spd) max_spd = speed;
    end
    check("rev_speed", speed, 50);
    check("rev_max", max_spd, 50);
    check("rev_rpm", rpm, 3051);
    #2 rst = 1'b1;
    #1;
    check("arst_speed", speed, 0);
    check("arst_rpm", rpm, 0);
    check("arst_gear", gear_num, 1);
    #2 rst = 1'b0;

    // Asynchronous reset in the middle of a shift
    do_reset();
    drive(2'd3, 8'd255, 1'b0, 1'b0);
    for (int t = 0; t < 32; t++) tick();
    check("rs_mid_shift", shifting, 1);
    #2 rst = 1'b1;
    #1;
    check("rs_shift", shifting, 0);
    check("rs_gear", gear_num, 1);
    #2 rst = 1'b0;
    for (int t = 0; t < 30; t++) tick();
    check("rs_again_speed", speed, 30);
    check("rs_again_gear", gear_num, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
